// File: rtl/fft_io_sequencer_pkg.sv
// Shared constants and state encoding for the FFT host-side I/O sequencer.
package fft_io_sequencer_pkg;

  // Bank address width; the frame spans four banks of 2**ADDR_W words.
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned N_PTS  = 4 * (2 ** ADDR_W);
  localparam int unsigned CNT_W  = ADDR_W + 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StUnload = 3'd4
  } state_e;

endpackage

// File: rtl/fft_io_skid_fifo.sv
// Small shift-style skid FIFO; the head entry is a register driving the outputs directly.
module fft_io_skid_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 18,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Depth-1:0] vld_q, vld_d;
  logic             placed;

  // Pop shifts toward the head; a push lands in the first free slot after that shift.
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop_i && vld_q[0]) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[Depth-1] = 1'b0;
    end
    if (push_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (!vld_d[i] && !placed) begin
          mem_d[i] = data_i;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  // Storage and valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      mem_q <= mem_d;
    end
  end

  assign valid_o = vld_q[0];
  assign data_o  = mem_q[0];
  assign count_o = CntW'($countones(vld_q));

endmodule

// File: rtl/fft_io_sequencer.sv
// Host-side scheduler for the 2048-pt radix-4 FFT core: loads a frame into the four RAM
// banks, starts the core, waits for done and streams the results out with backpressure.
module fft_io_sequencer
  import fft_io_sequencer_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WAIT_MAX = 65535
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iS_VALID,
  input  logic [15:0]       iS_DATA,
  output logic              oS_READY,
  output logic              oM_VALID,
  output logic [16:0]       oM_DATA,
  output logic              oM_LAST,
  input  logic              iM_READY,
  output logic              oFFT_START,
  output logic [15:0]       oFFT_DATA,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_0,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_1,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_2,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_3,
  output logic              oFFT_WE_0,
  output logic              oFFT_WE_1,
  output logic              oFFT_WE_2,
  output logic              oFFT_WE_3,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_0,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_1,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_2,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_3,
  input  logic [16:0]       iFFT_DATA_RE_0,
  input  logic [16:0]       iFFT_DATA_RE_1,
  input  logic [16:0]       iFFT_DATA_RE_2,
  input  logic [16:0]       iFFT_DATA_RE_3,
  input  logic              iFFT_RDY,
  output logic              oBUSY,
  output logic              oERR
);

  localparam int unsigned Depth = RD_LAT + 2;
  localparam int unsigned FcW   = $clog2(Depth + 1);
  localparam int unsigned TmrW  = $clog2(WAIT_MAX + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TmrW-1:0]     tmr_q;
  logic                s_ready_q, start_q, err_q, rdy_q, rd_done_q;
  logic [3:0]          we_q;
  logic [ADDR_W-1:0]   addr_wr_q;
  logic [15:0]         data_q;
  // Read pipeline: valid, bank select and last marker aligned with the RAM latency.
  logic [RD_LAT-1:0]   pv_q, pl_q;
  logic [1:0]          pb_q [RD_LAT];

  logic                accept, rdy_rise, last_idx, can_issue, pop, done_pop;
  logic                fifo_valid;
  logic [17:0]         fifo_data;
  logic [FcW-1:0]      fifo_cnt;
  logic [16:0]         rd_mux;
  int                  inflight;

  assign accept   = iS_VALID & s_ready_q;
  assign rdy_rise = iFFT_RDY & ~rdy_q;
  assign last_idx = (cnt_q == CNT_W'(N_PTS - 1));
  assign pop      = fifo_valid & iM_READY;
  assign done_pop = pop & fifo_data[17];

  // Issue a read only when the FIFO is guaranteed room for it once it lands.
  always_comb begin
    inflight  = $countones(pv_q);
    can_issue = (state_q == StUnload) && !rd_done_q &&
                ((int'(fifo_cnt) + inflight) < int'(Depth));
  end

  // Select the bank whose data is returning this cycle.
  always_comb begin
    rd_mux = '0;
    unique case (pb_q[RD_LAT-1])
      2'd0: rd_mux = iFFT_DATA_RE_0;
      2'd1: rd_mux = iFFT_DATA_RE_1;
      2'd2: rd_mux = iFFT_DATA_RE_2;
      2'd3: rd_mux = iFFT_DATA_RE_3;
    endcase
  end

  // Main FSM with registered write port, start/err pulses and read pipeline.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tmr_q     <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      rd_done_q <= 1'b0;
      we_q      <= '0;
      addr_wr_q <= '0;
      data_q    <= '0;
      pv_q      <= '0;
      pl_q      <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pb_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= '0;
      rdy_q   <= iFFT_RDY;
      pv_q[0] <= can_issue;
      pb_q[0] <= cnt_q[1:0];
      pl_q[0] <= last_idx;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        pb_q[i] <= pb_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      unique case (state_q)
        StIdle, StLoad: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            we_q      <= 4'b0001 << cnt_q[1:0];
            addr_wr_q <= cnt_q[CNT_W-1:2];
            data_q    <= iS_DATA;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (last_idx) begin
              s_ready_q <= 1'b0;
              tmr_q     <= '0;
              state_q   <= StStart;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StStart: begin
          // First cycle lets the last write commit; second issues the start pulse.
          if (tmr_q == '0) begin
            tmr_q <= TmrW'(1);
          end else begin
            tmr_q   <= '0;
            start_q <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (rdy_rise) begin
            tmr_q     <= '0;
            rd_done_q <= 1'b0;
            state_q   <= StUnload;
          end else if (tmr_q == TmrW'(WAIT_MAX - 1)) begin
            tmr_q     <= '0;
            err_q     <= 1'b1;
            s_ready_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StUnload: begin
          if (can_issue) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_idx) rd_done_q <= 1'b1;
          end
          if (done_pop) begin
            s_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fft_io_skid_fifo #(
    .Depth (Depth),
    .Width (18),
    .CntW  (FcW)
  ) u_skid (
    .clk_i   (iCLK),
    .rst_ni  (iRESET),
    .push_i  (pv_q[RD_LAT-1]),
    .data_i  ({pl_q[RD_LAT-1], rd_mux}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  assign oS_READY       = s_ready_q;
  assign oM_VALID       = fifo_valid;
  assign oM_DATA        = fifo_data[16:0];
  assign oM_LAST        = fifo_data[17];
  assign oFFT_START     = start_q;
  assign oFFT_DATA      = data_q;
  assign oFFT_ADDR_WR_0 = addr_wr_q;
  assign oFFT_ADDR_WR_1 = addr_wr_q;
  assign oFFT_ADDR_WR_2 = addr_wr_q;
  assign oFFT_ADDR_WR_3 = addr_wr_q;
  assign oFFT_WE_0      = we_q[0];
  assign oFFT_WE_1      = we_q[1];
  assign oFFT_WE_2      = we_q[2];
  assign oFFT_WE_3      = we_q[3];
  assign oFFT_ADDR_RD_0 = cnt_q[CNT_W-1:2];
  assign oFFT_ADDR_RD_1 = cnt_q[CNT_W-1:2];
  assign oFFT_ADDR_RD_2 = cnt_q[CNT_W-1:2];
  assign oFFT_ADDR_RD_3 = cnt_q[CNT_W-1:2];
  assign oBUSY          = (state_q != StIdle) || (cnt_q != '0);
  assign oERR           = err_q;

endmodule

// File: tb/tb_fft_io_sequencer.sv
// Directed bench for fft_io_sequencer with a behavioural model of the core's RAM banks.
module tb_fft_io_sequencer;

  localparam int NPts    = 2048;
  localparam int RdLat   = 1;
  localparam int WaitMax = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iS_VALID, iM_READY, iFFT_RDY;
  logic [15:0] iS_DATA;
  logic        oS_READY, oM_VALID, oM_LAST, oFFT_START, oBUSY, oERR;
  logic [16:0] oM_DATA;
  logic [15:0] oFFT_DATA;
  logic [8:0]  wa0, wa1, wa2, wa3, ra0, ra1, ra2, ra3;
  logic        we0, we1, we2, we3;
  logic [3:0]  we_vec;
  logic [16:0] ram [4][512];
  logic [16:0] rd_q [4];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign we_vec = {we3, we2, we1, we0};

  fft_io_sequencer #(
    .RD_LAT   (RdLat),
    .WAIT_MAX (WaitMax)
  ) dut (
    .iCLK           (clk),
    .iRESET         (rst_n),
    .iS_VALID       (iS_VALID),
    .iS_DATA        (iS_DATA),
    .oS_READY       (oS_READY),
    .oM_VALID       (oM_VALID),
    .oM_DATA        (oM_DATA),
    .oM_LAST        (oM_LAST),
    .iM_READY       (iM_READY),
    .oFFT_START     (oFFT_START),
    .oFFT_DATA      (oFFT_DATA),
    .oFFT_ADDR_WR_0 (wa0),
    .oFFT_ADDR_WR_1 (wa1),
    .oFFT_ADDR_WR_2 (wa2),
    .oFFT_ADDR_WR_3 (wa3),
    .oFFT_WE_0      (we0),
    .oFFT_WE_1      (we1),
    .oFFT_WE_2      (we2),
    .oFFT_WE_3      (we3),
    .oFFT_ADDR_RD_0 (ra0),
    .oFFT_ADDR_RD_1 (ra1),
    .oFFT_ADDR_RD_2 (ra2),
    .oFFT_ADDR_RD_3 (ra3),
    .iFFT_DATA_RE_0 (rd_q[0]),
    .iFFT_DATA_RE_1 (rd_q[1]),
    .iFFT_DATA_RE_2 (rd_q[2]),
    .iFFT_DATA_RE_3 (rd_q[3]),
    .iFFT_RDY       (iFFT_RDY),
    .oBUSY          (oBUSY),
    .oERR           (oERR)
  );

  function automatic logic [15:0] samp(int n, int s);
    return 16'(n * (2 * s + 1) + s * 1000);
  endfunction

  // The modelled core's "transform" is a fixed map, so each result traces to one sample.
  function automatic logic [16:0] core_f(logic [15:0] x);
    return {x[15], x} + 17'd3;
  endfunction

  // Core RAM: writes land at the edge, reads return one cycle later.
  always @(posedge clk) begin
    if (we0) ram[0][wa0] <= core_f(oFFT_DATA);
    if (we1) ram[1][wa1] <= core_f(oFFT_DATA);
    if (we2) ram[2][wa2] <= core_f(oFFT_DATA);
    if (we3) ram[3][wa3] <= core_f(oFFT_DATA);
    rd_q[0] <= ram[0][ra0];
    rd_q[1] <= ram[1][ra1];
    rd_q[2] <= ram[2][ra2];
    rd_q[3] <= ram[3][ra3];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {22'd0, oS_READY, oM_VALID, oM_LAST, oFFT_START, we_vec, oBUSY, oERR},
             32'd0);
    check_eq({tag, "_wr"}, {7'd0, wa0, oFFT_DATA}, 32'd0);
    check_eq({tag, "_md"}, {15'd0, oM_DATA}, 32'd0);
  endtask

  // Streams one frame; abort_at >= 0 asserts reset once that many beats went in.
  task automatic load_frame(input int s, input int abort_at);
    int n;
    int guard;
    logic rb;
    n = 0;
    guard = 0;
    iS_VALID = 1'b1;
    iS_DATA  = samp(0, s);
    while (n < NPts && guard < 3 * NPts) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        iS_VALID = 1'b0;
        return;
      end
      rb = oS_READY;
      step();
      guard++;
      if (rb) begin
        check_eq("wr", {3'd0, we_vec, wa0, oFFT_DATA},
                 {3'd0, 4'b0001 << (n % 4), 9'(n / 4), samp(n, s)});
        n++;
        iS_DATA = samp(n, s);
      end
    end
    check_eq("load_n", n, NPts);
    check_eq("rdy_drop", oS_READY, 1'b0);
    step();
    check_eq("start_gap", oFFT_START, 1'b0);
    step();
    check_eq("start", oFFT_START, 1'b1);
    check_eq("stall", oS_READY, 1'b0);
    iS_VALID = 1'b0;
    step();
    check_eq("start_once", oFFT_START, 1'b0);
  endtask

  // Raises core done and drains the frame, checking order, LAST, hold and latency.
  task automatic unload(input int s, input bit rnd);
    int n, cyc, lat, first, lastc;
    logic held;
    logic [17:0] prev;
    n = 0;
    cyc = 0;
    first = -1;
    lastc = 0;
    held = 1'b0;
    prev = '0;
    iM_READY = 1'b1;
    iFFT_RDY = 1'b1;
    lat = 0;
    // Rise seen at the next edge, then RD_LAT+1 cycles from UNLOAD entry.
    do begin
      step();
      lat++;
    end while (!oM_VALID && lat < 20);
    check_eq("lat", lat, RdLat + 2);
    while (n < NPts && cyc < 8 * NPts) begin
      iM_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        check_eq("hold_v", oM_VALID, 1'b1);
        check_eq("hold_d", {oM_LAST, oM_DATA}, prev);
      end
      if (oM_VALID) begin
        if (iM_READY) begin
          check_eq("res", {oM_LAST, oM_DATA}, {n == NPts - 1, core_f(samp(n, s))});
          if (first < 0) first = cyc;
          lastc = cyc;
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = {oM_LAST, oM_DATA};
        end
      end else begin
        held = 1'b0;
      end
      step();
      cyc++;
    end
    iM_READY = 1'b1;
    check_eq("res_n", n, NPts);
    if (!rnd) check_eq("thru", lastc - first + 1, NPts);
    check_eq("idle_rdy", oS_READY, 1'b1);
    check_eq("idle_mv", oM_VALID, 1'b0);
    check_eq("idle_busy", oBUSY, 1'b0);
  endtask

  initial begin
    int k;
    logic mv;
    rst_n    = 1'b0;
    iS_VALID = 1'b0;
    iS_DATA  = '0;
    iM_READY = 1'b1;
    iFFT_RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    #1;
    check_eq("rdy_pre", oS_READY, 1'b0);
    step();
    check_eq("rdy_rise", oS_READY, 1'b1);
    check_eq("busy0", oBUSY, 1'b0);

    // Frame of 0..2047, core done 100 cycles after start, full ready.
    load_frame(0, -1);
    repeat (98) step();
    check_eq("wait_mv", oM_VALID, 1'b0);
    unload(0, 1'b0);

    // Random backpressure.
    iFFT_RDY = 1'b0;
    step();
    load_frame(1, -1);
    repeat (98) step();
    unload(1, 1'b1);

    // Done edge while idle is ignored; level high at WAIT entry is ignored too.
    iFFT_RDY = 1'b0;
    repeat (3) step();
    iFFT_RDY = 1'b1;
    repeat (2) step();
    check_eq("idle_edge_busy", oBUSY, 1'b0);
    check_eq("idle_edge_mv", oM_VALID, 1'b0);
    load_frame(2, -1);
    repeat (10) step();
    check_eq("lvl_mv", oM_VALID, 1'b0);
    check_eq("lvl_busy", oBUSY, 1'b1);
    iFFT_RDY = 1'b0;
    repeat (5) step();
    check_eq("low_mv", oM_VALID, 1'b0);
    unload(2, 1'b0);

    // Timeout: done never rises.
    iFFT_RDY = 1'b0;
    load_frame(3, -1);
    k = 1;  // load_frame returns one cycle after the start pulse
    mv = 1'b0;
    while (k < 1200) begin
      step();
      k++;
      if (oM_VALID) mv = 1'b1;
      if (oERR) break;
    end
    check_eq("err_at", k, WaitMax);
    check_eq("err_rdy", oS_READY, 1'b1);
    check_eq("err_busy", oBUSY, 1'b0);
    step();
    check_eq("err_once", oERR, 1'b0);
    check_eq("err_mv", mv, 1'b0);

    // Reset at beat 700, then a fresh frame.
    load_frame(4, 700);
    repeat (2) step();
    check_quiet("rst_hold");
    rst_n = 1'b1;
    step();
    check_eq("rst_rdy", oS_READY, 1'b1);
    check_eq("rst_busy", oBUSY, 1'b0);
    load_frame(5, -1);
    repeat (20) step();
    unload(5, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
